// File: rtl/tt_uart_pkg.sv
// Shared definitions for the tile UART transmitter.
//   tx_state_e    : transmitter FSM states
//   DATA_BITS     : payload bits per frame
//   UIO_* / UO_*  : bit positions on the tile pin buses
//   frame_parity(): parity bit for a data byte (even when odd=0)
package tt_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DATA_BITS = 8;

  localparam int UIO_STROBE  = 0;
  localparam int UIO_PAR_EN  = 1;
  localparam int UIO_PAR_ODD = 2;

  localparam int UO_TX      = 0;
  localparam int UO_BUSY    = 1;
  localparam int UO_FULL    = 2;
  localparam int UO_OVF     = 3;
  localparam int UO_EMPTY   = 4;
  localparam int UO_LVL_LSB = 5;
  localparam int UO_LVL_MSB = 7;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] data,
                                        input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO feeding the UART transmitter.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_push       : write request (i_wr_data captured when accepted)
//   i_pop        : read request (o_rd_data is the head entry, valid while !o_empty)
//   o_full       : level == DEPTH
//   o_empty      : level == 0
//   o_level      : occupancy 0..DEPTH
//   o_drop       : a push was refused this cycle because the FIFO stayed full
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level,
  output logic             o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LVL_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_rd_ptr;

  logic [LVL_W-1:0] w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;

  // Pointers carry one extra bit so full and empty differ without a flag.
  assign w_level = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_level == LVL_W'(DEPTH));
  assign w_empty = (w_level == '0);

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when the head is being consumed.
  assign w_do_pop  = i_pop & ~w_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);

  assign w_wr_idx = (DEPTH == 1) ? '0 : r_wr_ptr[AW-1:0];
  assign w_rd_idx = (DEPTH == 1) ? '0 : r_rd_ptr[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[w_wr_idx] <= i_wr_data;
  end

  assign o_rd_data = r_mem[w_rd_idx];
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_level   = w_level;
  assign o_drop    = i_push & ~w_do_push;

endmodule

// File: rtl/tt_um_uart_tx.sv
// Tile-level UART transmitter (8N1 / 8E1 / 8O1).
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : tile enable, unused
//   ui_in      : byte to enqueue
//   uio_in     : [0] write strobe (rising edge), [1] parity enable, [2] parity odd
//   uo_out     : [0] tx, [1] busy, [2] full, [3] overflow (sticky), [4] empty, [7:5] level
//   uio_out    : tied 0
//   uio_oe     : tied 0, all bidirectional pins are inputs
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) for CLKS_PER_BIT cycles
// DATA   | eight data bits, LSB first, CLKS_PER_BIT cycles each
// PARITY | optional parity bit, only when enabled at frame start
// STOP   | stop bit (high); pops the next byte straight into START
module tt_um_uart_tx
  import tt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int          LVL_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

  tx_state_e              r_state;
  tx_state_e              w_state_nx;
  logic [15:0]            r_baud;
  logic [15:0]            w_baud_nx;
  logic [2:0]             r_bit_idx;
  logic [2:0]             w_bit_idx_nx;
  logic [DATA_BITS-1:0]   r_data;
  logic [DATA_BITS-1:0]   w_data_nx;
  logic                   r_par_en;
  logic                   w_par_en_nx;
  logic                   r_par_odd;
  logic                   w_par_odd_nx;
  logic                   r_tx;
  logic                   w_tx_nx;
  logic                   r_stb_prev;
  logic                   r_overflow;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_load;
  logic                   w_baud_done;
  logic [DATA_BITS-1:0]   w_fifo_data;
  logic                   w_full;
  logic                   w_empty;
  logic [LVL_W-1:0]       w_level;
  logic                   w_drop;
  logic                   w_unused;

  assign w_push = uio_in[UIO_STROBE] & ~r_stb_prev;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_wr_data (ui_in),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (w_level),
    .o_drop    (w_drop)
  );

  assign w_baud_done = (r_baud == '0);

  always_comb begin
    w_state_nx   = r_state;
    w_baud_nx    = r_baud;
    w_bit_idx_nx = r_bit_idx;
    w_data_nx    = r_data;
    w_par_en_nx  = r_par_en;
    w_par_odd_nx = r_par_odd;
    w_tx_nx      = r_tx;
    w_load       = 1'b0;
    w_pop        = 1'b0;

    // Every bit period ends with a reload, whichever state comes next.
    if (r_state != IDLE) begin
      w_baud_nx = w_baud_done ? BAUD_RELOAD : r_baud - 16'd1;
    end

    case (r_state)
      IDLE: begin
        w_tx_nx = 1'b1;
        if (!w_empty) w_load = 1'b1;
      end
      START: begin
        if (w_baud_done) begin
          w_state_nx   = DATA;
          w_bit_idx_nx = 3'd0;
          w_tx_nx      = r_data[0];
        end
      end
      DATA: begin
        if (w_baud_done) begin
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
            if (r_par_en) begin
              w_state_nx = PARITY;
              w_tx_nx    = frame_parity(r_data, r_par_odd);
            end else begin
              w_state_nx = STOP;
              w_tx_nx    = 1'b1;
            end
          end else begin
            w_bit_idx_nx = r_bit_idx + 3'd1;
            w_tx_nx      = r_data[w_bit_idx_nx];
          end
        end
      end
      PARITY: begin
        if (w_baud_done) begin
          w_state_nx = STOP;
          w_tx_nx    = 1'b1;
        end
      end
      STOP: begin
        if (w_baud_done) begin
          if (!w_empty) begin
            w_load = 1'b1;
          end else begin
            w_state_nx = IDLE;
            w_tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_tx_nx    = 1'b1;
      end
    endcase

    // Frame start: take the head byte and freeze the parity config so
    // later pin changes cannot corrupt the frame in flight.
    if (w_load) begin
      w_pop        = 1'b1;
      w_data_nx    = w_fifo_data;
      w_par_en_nx  = uio_in[UIO_PAR_EN];
      w_par_odd_nx = uio_in[UIO_PAR_ODD];
      w_state_nx   = START;
      w_baud_nx    = BAUD_RELOAD;
      w_tx_nx      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_data     <= '0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_tx       <= 1'b1;
      // Track the strobe during reset so one already high at release
      // is not mistaken for a fresh rising edge.
      r_stb_prev <= uio_in[UIO_STROBE];
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_baud     <= w_baud_nx;
      r_bit_idx  <= w_bit_idx_nx;
      r_data     <= w_data_nx;
      r_par_en   <= w_par_en_nx;
      r_par_odd  <= w_par_odd_nx;
      r_tx       <= w_tx_nx;
      r_stb_prev <= uio_in[UIO_STROBE];
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign uo_out[UO_TX]                  = r_tx;
  assign uo_out[UO_BUSY]                = (r_state != IDLE);
  assign uo_out[UO_FULL]                = w_full;
  assign uo_out[UO_OVF]                 = r_overflow;
  assign uo_out[UO_EMPTY]               = w_empty;
  assign uo_out[UO_LVL_MSB:UO_LVL_LSB]  = 3'(w_level);

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

  assign w_unused = &{1'b0, ena, uio_in[7:3]};

endmodule

// File: tb/tb_tt_um_uart_tx.sv
module tb_tt_um_uart_tx;

  localparam int N = 16;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_uart_tx #(
    .CLKS_PER_BIT (N),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  // Reference model: queue of accepted bytes (with the edge they were
  // written on) and the frame currently on the line as a bit schedule.
  logic [7:0]  m_q[$];
  int          m_qe[$];
  bit          m_active = 1'b0;
  int          m_start = 0;
  int          m_len = 0;
  logic [10:0] m_bits = '1;
  logic        m_prev = 1'b0;
  logic        m_ovf = 1'b0;
  int          m_t = 0;

  int n_checks = 0;
  int n_errors = 0;
  int run_cnt = 0;
  int last_run = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, m_t);
    end
  endtask

  task automatic model_edge();
    logic       stb;
    logic [7:0] d;
    stb = uio_in[0];
    if (!rst_n) begin
      m_q.delete();
      m_qe.delete();
      m_active = 1'b0;
      m_ovf    = 1'b0;
      m_prev   = stb;
      return;
    end
    if (m_active && m_t == m_start + m_len) m_active = 1'b0;
    if (!m_active && m_q.size() > 0 && m_qe[0] < m_t) begin
      d = m_q.pop_front();
      void'(m_qe.pop_front());
      m_bits      = '1;
      m_bits[0]   = 1'b0;
      m_bits[8:1] = d;
      if (uio_in[1]) begin
        m_bits[9] = (^d) ^ uio_in[2];
        m_len     = 11 * N;
      end else begin
        m_len = 10 * N;
      end
      m_active = 1'b1;
      m_start  = m_t;
    end
    if (stb && !m_prev) begin
      if (m_q.size() < D) begin
        m_q.push_back(ui_in);
        m_qe.push_back(m_t);
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_prev = stb;
  endtask

  function automatic logic [23:0] exp_vec();
    logic tx;
    int   lvl;
    lvl = m_q.size();
    tx  = m_active ? m_bits[(m_t - m_start) / N] : 1'b1;
    return {16'h0000, 3'(lvl), (lvl == 0), m_ovf, (lvl == D), m_active, tx};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_t++;
    model_edge();
    @(negedge clk);
    check_eq("pins", {8'h00, uio_oe, uio_out, uo_out}, {8'h00, exp_vec()});
    if (uo_out[1]) run_cnt++;
    else begin
      if (run_cnt > 0) last_run = run_cnt;
      run_cnt = 0;
    end
  endtask

  task automatic push(input logic [7:0] d);
    ui_in     = d;
    uio_in[0] = 1'b1;
    tick();
    uio_in[0] = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input int limit);
    int i;
    i = 0;
    while ((uo_out[1] !== 1'b0 || uo_out[4] !== 1'b1) && i < limit) begin
      tick();
      i++;
    end
    check_eq("idle_reached", {30'd0, uo_out[1], uo_out[4]}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    last_run = 0;
  endtask

  initial begin
    int i;
    int r;

    rst_n  = 1'b0;
    uio_in = 8'h00;
    repeat (3) tick();
    check_eq("rst_uo", uo_out, 8'h11);
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("idle_tx", uo_out[0], 1'b1);
    last_run = 0;

    // 8N1 frame of 0xA5
    push(8'hA5);
    wait_idle(400);
    check_eq("len_8n1", last_run, 160);

    // even then odd parity
    uio_in[2:1] = 2'b01;
    push(8'hA5);
    wait_idle(400);
    check_eq("len_8e1", last_run, 176);
    uio_in[2:1] = 2'b11;
    push(8'hA5);
    wait_idle(400);
    check_eq("len_8o1", last_run, 176);
    uio_in[2:1] = 2'b00;

    // three back-to-back frames
    push(8'h01);
    push(8'h02);
    push(8'h03);
    check_eq("lvl_b2b", uo_out[7:5], 3'd2);
    wait_idle(800);
    check_eq("len_b2b", last_run, 480);
    check_eq("empty_b2b", uo_out[4], 1'b1);

    // overflow: one in flight, six more offered, four fit
    push(8'h10);
    for (int k = 0; k < 6; k++) push(8'h20 + 8'(k));
    check_eq("ovf_full", uo_out[2], 1'b1);
    check_eq("ovf_set", uo_out[3], 1'b1);
    check_eq("ovf_lvl", uo_out[7:5], 3'd4);
    wait_idle(1200);
    check_eq("len_ovf", last_run, 800);
    check_eq("ovf_sticky", uo_out[3], 1'b1);
    do_reset();
    check_eq("ovf_cleared", uo_out[3], 1'b0);

    // strobe held high for 50 cycles pushes once
    ui_in     = 8'h5A;
    uio_in[0] = 1'b1;
    repeat (50) tick();
    uio_in[0] = 1'b0;
    wait_idle(400);
    check_eq("len_hold", last_run, 160);
    check_eq("lvl_hold", uo_out[7:5], 3'd0);

    // reset in the middle of data bit 3 with two bytes queued
    push(8'h3C);
    push(8'hC3);
    push(8'h81);
    i = 0;
    while (!(m_active && (m_t - m_start) == 4 * N + 8) && i < 400) begin
      tick();
      i++;
    end
    check_eq("busy_mid", {uo_out[1], uo_out[7:5]}, {1'b1, 3'd2});
    rst_n = 1'b0;
    tick();
    check_eq("rst_mid", uo_out, 8'h11);
    rst_n    = 1'b1;
    last_run = 0;
    repeat (400) tick();
    check_eq("no_frame_after_rst", last_run + run_cnt, 0);

    // randomized traffic: alternating dense and sparse strobe phases
    for (int k = 0; k < 6000; k++) begin
      r = $urandom_range(0, 999);
      if (((k / 1000) % 2) == 0) begin
        if (r < 120) uio_in[0] = ~uio_in[0];
      end else begin
        if (r < 8) uio_in[0] = ~uio_in[0];
      end
      if (!uio_in[0]) ui_in = 8'($urandom);
      if ($urandom_range(0, 63) == 0) uio_in[2:1] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) uio_in[7:3] = 5'($urandom);
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n     = 1'b1;
    uio_in[0] = 1'b0;
    tick();
    wait_idle(2000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
